// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one MMIO port between the core memory stage (m0)
// and the debug loader (m1). One transaction in flight: IDLE -> ISSUE -> RESP.
module mmio_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_enable,

  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  mmio_sel,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic                  mmio_we,
  output logic [DATA_WIDTH-1:0] mmio_wdata,
  input  logic [DATA_WIDTH-1:0] mmio_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                state_q;
  logic                  last_grant_q;
  logic                  gnt_id_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  logic any_valid_c;
  logic grant_id_c;
  logic accept_c;
  logic resp0_c;
  logic resp1_c;

  // Round-robin pick: a tie goes to the requester not granted last time.
  always_comb begin
    any_valid_c = m0_valid | m1_valid;
    grant_id_c  = 1'b0;
    if (m0_valid && m1_valid) begin
      grant_id_c = ~last_grant_q;
    end else begin
      grant_id_c = m1_valid;
    end
  end

  // A grant only exists in IDLE on an enabled cycle outside reset.
  assign accept_c = rst_n & clk_enable & (state_q == S_IDLE) & any_valid_c;
  assign m0_ready = accept_c & ~grant_id_c;
  assign m1_ready = accept_c &  grant_id_c;

  // MMIO read data is registered by the MMIO block and only becomes valid in
  // RESP, so the response pulse and data are presented in that same cycle and
  // the data is captured locally to hold it afterwards.
  assign resp0_c   = (state_q == S_RESP) & ~gnt_id_q;
  assign resp1_c   = (state_q == S_RESP) &  gnt_id_q;
  assign m0_rvalid = resp0_c & clk_enable;
  assign m1_rvalid = resp1_c & clk_enable;
  assign m0_rdata  = resp0_c ? mmio_rdata : rdata0_q;
  assign m1_rdata  = resp1_c ? mmio_rdata : rdata1_q;

  // Transaction sequencer; all state advances only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      mmio_sel     <= 1'b0;
      mmio_we      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wdata   <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else if (clk_enable) begin
      case (state_q)
        S_IDLE: begin
          if (any_valid_c) begin
            state_q      <= S_ISSUE;
            gnt_id_q     <= grant_id_c;
            last_grant_q <= grant_id_c;
            mmio_sel     <= 1'b1;
            mmio_addr    <= grant_id_c ? m1_addr  : m0_addr;
            mmio_we      <= grant_id_c ? m1_we    : m0_we;
            mmio_wdata   <= grant_id_c ? m1_wdata : m0_wdata;
          end
        end
        S_ISSUE: begin
          state_q  <= S_RESP;
          mmio_sel <= 1'b0;
          mmio_we  <= 1'b0;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (gnt_id_q) begin
            rdata1_q <= mmio_rdata;
          end else begin
            rdata0_q <= mmio_rdata;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: directed scenarios plus randomized traffic, with an
// MMIO register model and a transaction-level scoreboard.
module tb_mmio_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_enable = 1'b1;

  logic        m0_valid = 1'b0;
  logic        m0_we = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m0_ready;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_valid = 1'b0;
  logic        m1_we = 1'b0;
  logic [31:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_ready;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic        mmio_sel;
  logic [31:0] mmio_addr;
  logic        mmio_we;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt = 0;
  bit rand_run = 1'b0;

  mmio_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mmio_sel(mmio_sel), .mmio_addr(mmio_addr), .mmio_we(mmio_we),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(input bit ok, input string nm,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Count of enabled clock edges outside reset.
  always @(posedge clk) begin
    if (rst_n && clk_enable) en_cnt <= en_cnt + 1;
  end

  // MMIO register file: registered read data, read-before-write, 8 words.
  logic [31:0] mem [8];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0000_1234;
      mem_init <= 1'b1;
    end else if (clk_enable && mmio_sel) begin
      mmio_rdata <= mem[mmio_addr[4:2]];
      if (mmio_we) mem[mmio_addr[4:2]] <= mmio_wdata;
    end
  end

  // Reference model: transactions complete in accept order; a read (or a
  // write acknowledge) returns the word's value just before that transaction.
  typedef struct {
    int          id;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] old;
    int          acc;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        bus_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          outstanding = 0;
  bit          last_w = 1'b1;
  bit          have_prev = 1'b0;
  int          prev_acc = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0000_1234;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    txn_t        t;
    bit          w;
    logic        v;
    logic [31:0] d;
    if (!rst_n) begin
      while (exp_q.size() > 0) begin
        t = exp_q.pop_back();
        if (t.we) ref_mem[t.addr] = t.old;
      end
      bus_q.delete();
      outstanding = 0;
      last_w = 1'b1;
      have_prev = 1'b0;
    end else begin
      if (!clk_enable)
        chk(!(m0_ready || m1_ready || m0_rvalid || m1_rvalid), "gated_handshake",
            32'({m0_ready, m1_ready, m0_rvalid, m1_rvalid}), 32'h0);
      chk(!(m0_ready && m1_ready), "single_ready", 32'({m0_ready, m1_ready}), 32'h0);
      if (outstanding > 0) begin
        chk(!(m0_ready || m1_ready), "busy_ready", 32'({m0_ready, m1_ready}), 32'h0);
      end else if (clk_enable && (m0_valid || m1_valid)) begin
        w = (m0_valid && m1_valid) ? !last_w : m1_valid;
        chk((m0_ready == !w) && (m1_ready == w), "rr_grant",
            32'({m0_ready, m1_ready}), 32'({!w, w}));
      end

      if ((m0_valid && m0_ready) || (m1_valid && m1_ready)) begin
        t.id    = (m1_valid && m1_ready) ? 1 : 0;
        t.addr  = (t.id == 1) ? m1_addr  : m0_addr;
        t.we    = (t.id == 1) ? m1_we    : m0_we;
        t.wdata = (t.id == 1) ? m1_wdata : m0_wdata;
        t.old   = ref_rd(t.addr);
        t.acc   = en_cnt;
        if (t.we) ref_mem[t.addr] = t.wdata;
        if (have_prev)
          chk(en_cnt - prev_acc >= 3, "accept_spacing", 32'(en_cnt - prev_acc), 32'd3);
        have_prev = 1'b1;
        prev_acc  = en_cnt;
        last_w    = (t.id == 1);
        outstanding++;
        exp_q.push_back(t);
        bus_q.push_back(t);
      end

      if (clk_enable && mmio_sel) begin
        if (bus_q.size() == 0) begin
          chk(1'b0, "spurious_sel", 32'(mmio_sel), 32'h0);
        end else begin
          t = bus_q.pop_front();
          chk(mmio_addr == t.addr, "mmio_addr", mmio_addr, t.addr);
          chk(mmio_we == t.we, "mmio_we", 32'(mmio_we), 32'(t.we));
          chk(mmio_wdata == t.wdata, "mmio_wdata", mmio_wdata, t.wdata);
          chk(en_cnt == t.acc + 1, "issue_cycle", 32'(en_cnt), 32'(t.acc + 1));
        end
      end
      if (!mmio_sel) chk(!mmio_we, "we_qualified", 32'(mmio_we), 32'h0);

      for (int r = 0; r < 2; r++) begin
        v = (r == 0) ? m0_rvalid : m1_rvalid;
        d = (r == 0) ? m0_rdata  : m1_rdata;
        if (v) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "spurious_rvalid", 32'(r), 32'hFFFF_FFFF);
          end else begin
            t = exp_q.pop_front();
            chk(t.id == r, "rvalid_owner", 32'(r), 32'(t.id));
            chk(d == t.old, "rdata", d, t.old);
            chk(en_cnt == t.acc + 2, "resp_latency", 32'(en_cnt), 32'(t.acc + 2));
            outstanding--;
          end
        end
      end
    end
  end

  // Issue one request and hold it until accepted; called at posedge+1.
  task automatic req(input int id, input logic [31:0] a, input logic w, input logic [31:0] d);
    bit done;
    done = 1'b0;
    if (id == 0) begin
      m0_addr = a; m0_we = w; m0_wdata = d; m0_valid = 1'b1;
    end else begin
      m1_addr = a; m1_we = w; m1_wdata = d; m1_valid = 1'b1;
    end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (id == 0) ? m0_ready : m1_ready;
    end
    if (!done) chk(1'b0, "req_timeout", 32'(id), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    if (id == 0) m0_valid = 1'b0;
    else         m1_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic rnd_master(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      req(id, 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4, 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clk_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(mmio_sel == 1'b0 && mmio_we == 1'b0, "rst_sel_we", 32'({mmio_sel, mmio_we}), 32'h0);
    chk(mmio_addr == 32'h0, "rst_addr", mmio_addr, 32'h0);
    chk(mmio_wdata == 32'h0, "rst_wdata", mmio_wdata, 32'h0);
    chk(!m0_rvalid && !m1_rvalid, "rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
    chk(m0_rdata == 32'h0 && m1_rdata == 32'h0, "rst_rdata", m0_rdata | m1_rdata, 32'h0);
    chk(!m0_ready && !m1_ready, "rst_ready", 32'({m0_ready, m1_ready}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // m0 write then read back
    req(0, 32'h1000, 1'b1, 32'h0000_ABCD);
    chk(mmio_sel && mmio_we && mmio_addr == 32'h1000, "t1_issue", mmio_addr, 32'h1000);
    @(posedge clk); #1;
    chk(m0_rvalid && !m1_rvalid, "t1_wack", 32'({m0_rvalid, m1_rvalid}), 32'h2);
    @(posedge clk); #1;
    req(0, 32'h1000, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk(m0_rvalid && m0_rdata == 32'h0000_ABCD, "t1_read", m0_rdata, 32'h0000_ABCD);
    @(posedge clk); #1;
    chk(!m0_rvalid && m0_rdata == 32'h0000_ABCD, "t1_rdata_hold", m0_rdata, 32'h0000_ABCD);

    // clk_enable gating during one m1 read
    fork
      req(1, 32'h1000, 1'b0, 32'h0);
      begin
        for (int i = 0; i < 10; i++) begin
          clk_enable = (i % 2 == 0);
          @(posedge clk); #1;
        end
        clk_enable = 1'b1;
      end
    join
    chk(m1_rdata == 32'h0000_ABCD, "gated_rdata", m1_rdata, 32'h0000_ABCD);
    settle();

    // m1 arrives while m0 is in ISSUE
    fork
      req(0, 32'h1004, 1'b1, 32'h0000_1111);
      begin
        @(posedge clk); #1;
        m1_addr = 32'h1018; m1_we = 1'b0; m1_wdata = 32'h0; m1_valid = 1'b1;
        #3;
        chk(!m1_ready, "busy_no_ready", 32'(m1_ready), 32'h0);
        req(1, 32'h1018, 1'b0, 32'h0);
      end
    join
    settle();

    // write acknowledge carries pre-write value
    req(1, 32'h1014, 1'b1, 32'h0000_5678);
    @(posedge clk); #1;
    chk(m1_rvalid && m1_rdata == 32'h0000_1234, "wack_old", m1_rdata, 32'h0000_1234);
    chk(!m0_rvalid, "wack_other", 32'(m0_rvalid), 32'h0);
    @(posedge clk); #1;
    req(1, 32'h1014, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk(m1_rvalid && m1_rdata == 32'h0000_5678, "wack_new", m1_rdata, 32'h0000_5678);
    settle();

    // reset while a write sits in ISSUE
    req(0, 32'h1008, 1'b1, 32'h0000_DEAD);
    chk(mmio_sel == 1'b1, "pre_rst_sel", 32'(mmio_sel), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk(!mmio_sel && !mmio_we, "rst_mid_sel", 32'({mmio_sel, mmio_we}), 32'h0);
    chk(mmio_addr == 32'h0, "rst_mid_addr", mmio_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // four back-to-back ties: expected grant order m0, m1, m0, m1
    fork
      begin req(0, 32'h1000, 1'b0, 32'h0); req(0, 32'h100C, 1'b1, 32'h0000_0C0C); end
      begin req(1, 32'h1004, 1'b0, 32'h0); req(1, 32'h1008, 1'b0, 32'h0); end
    join
    @(posedge clk); #1;
    chk(m1_rvalid && m1_rdata == 32'h0000_1234, "dropped_write", m1_rdata, 32'h0000_1234);
    settle();

    // randomized traffic with random clk_enable
    rand_run = 1'b1;
    fork
      begin
        fork
          rnd_master(0, 40);
          rnd_master(1, 40);
        join
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          clk_enable = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        clk_enable = 1'b1;
      end
    join
    repeat (6) begin @(posedge clk); #1; end
    chk(exp_q.size() == 0, "drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
